// File: rtl/mask_deserializer_pkg.sv
// =============================================================================
// Package : mask_pkg
// Purpose : Shared types and chunk-count lookup for the mask deserializer.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

package mask_pkg;

   localparam int STEP_SEL0 = 16;   // 320 / 20
   localparam int STEP_SEL1 = 32;   // 640 / 20
   localparam int STEP_SEL2 = 54;   // 1080 / 20
   localparam int COUNT_W   = $clog2(STEP_SEL2);

   typedef enum logic [1:0] {
      RES_320  = 2'b00,
      RES_640  = 2'b01,
      RES_1080 = 2'b10
   } res_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } deser_state_t;

   function automatic logic [COUNT_W-1:0] steps_for(input res_t res);
      case (res)
         RES_320:  steps_for = COUNT_W'(STEP_SEL0);
         RES_640:  steps_for = COUNT_W'(STEP_SEL1);
         default:  steps_for = COUNT_W'(STEP_SEL2);
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mask_deserializer.sv
// =============================================================================
// Module  : mask_deserializer
// Purpose : Reassembles serial mask chunks into one wide, double-buffered mask.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module mask_deserializer
   import mask_pkg::*;
#(
   parameter int IP_CHANNEL_WIDTH = 1080,
   parameter int OP_CHANNEL_WIDTH = 20
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clk_en,
   input  logic                        start,
   input  logic [1:0]                  imageResolution,
   input  logic [OP_CHANNEL_WIDTH-1:0] DIN,
   input  logic                        din_valid,
   output logic [IP_CHANNEL_WIDTH-1:0] DOUT,
   output logic                        mask_valid,
   output logic                        busy,
   output logic                        err
);

   deser_state_t                state;
   res_t                        res_q;
   logic [COUNT_W-1:0]          count;
   logic [IP_CHANNEL_WIDTH-1:0] acc;
   logic [IP_CHANNEL_WIDTH-1:0] merged;
   logic                        last_chunk;
   logic                        start_legal;

   assign start_legal = (imageResolution != 2'b11);
   assign last_chunk  = (count == steps_for(res_q) - COUNT_W'(1));
   assign busy        = (state == FILL);

   // The completing chunk must reach DOUT in the same cycle it is sampled,
   // so the write is formed combinationally and shared by acc and DOUT.
   always_comb begin
      merged = acc;
      merged[int'(count) * OP_CHANNEL_WIDTH +: OP_CHANNEL_WIDTH] = DIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         res_q      <= RES_320;
         count      <= '0;
         acc        <= '0;
         DOUT       <= '0;
         mask_valid <= 1'b0;
         err        <= 1'b0;
      end else if (clk_en) begin
         mask_valid <= 1'b0;
         // start outranks din_valid in either state; an illegal start also
         // abandons any fill in progress.
         if (start) begin
            count <= '0;
            acc   <= '0;
            if (start_legal) begin
               state <= FILL;
               res_q <= res_t'(imageResolution);
            end else begin
               state <= IDLE;
               err   <= 1'b1;
            end
         end else if (din_valid) begin
            if (state == FILL) begin
               acc <= merged;
               if (last_chunk) begin
                  DOUT       <= merged;
                  mask_valid <= 1'b1;
                  state      <= IDLE;
                  count      <= '0;
               end else begin
                  count <= count + COUNT_W'(1);
               end
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mask_deserializer.sv
// =============================================================================
// Module  : tb_mask_deserializer
// Purpose : Scoreboard bench for mask_deserializer with directed scenarios.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_mask_deserializer;

   localparam int IPW = 1080;
   localparam int OPW = 20;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           clk_en;
   logic           start;
   logic [1:0]     imageResolution;
   logic [OPW-1:0] DIN;
   logic           din_valid;
   logic [IPW-1:0] DOUT;
   logic           mask_valid;
   logic           busy;
   logic           err;

   int             checks = 0;
   int             errors = 0;
   int             pulses = 0;
   logic [IPW-1:0] exp_q[$];
   logic           prev_mv = 1'b0;

   mask_deserializer #(.IP_CHANNEL_WIDTH(IPW), .OP_CHANNEL_WIDTH(OPW)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
      .imageResolution(imageResolution), .DIN(DIN), .din_valid(din_valid),
      .DOUT(DOUT), .mask_valid(mask_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_mask(input string name, input logic [IPW-1:0] act, input logic [IPW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int i = 0; i < IPW / OPW; i++) begin
            if (act[i*OPW +: OPW] !== exp[i*OPW +: OPW]) begin
               $display("FAIL %s: chunk %0d got %05h expected %05h",
                        name, i, act[i*OPW +: OPW], exp[i*OPW +: OPW]);
               break;
            end
         end
      end
   endtask

   function automatic logic [IPW-1:0] build(input int n, input logic [OPW-1:0] base);
      logic [IPW-1:0] m;
      m = '0;
      for (int k = 0; k < n; k++) m[k*OPW +: OPW] = base + OPW'(k);
      return m;
   endfunction

   // Monitor: one scoreboard pop per rising edge of mask_valid
   always @(negedge clk) begin
      if (mask_valid === 1'b1 && !prev_mv) begin
         pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mask: mask_valid pulse got, none expected");
         end else begin
            chk_mask("mask_out", DOUT, exp_q.pop_front());
         end
      end
      prev_mv = (mask_valid === 1'b1);
   end

   task automatic drive_chunk(input logic [OPW-1:0] d);
      @(negedge clk);
      clk_en = 1'b1; start = 1'b0; din_valid = 1'b1; DIN = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         clk_en = 1'b1; start = 1'b0; din_valid = 1'b0;
      end
   endtask

   task automatic do_start(input logic [1:0] r, input logic dv);
      @(negedge clk);
      clk_en = 1'b1; start = 1'b1; imageResolution = r; din_valid = dv; DIN = 20'hDEAD0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      chk_w(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      start = 1'b0; din_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk_mask({name, "_dout"}, DOUT, '0);
      chk_bit({name, "_busy"}, busy, 1'b0);
      chk_bit({name, "_mv"}, mask_valid, 1'b0);
      chk_bit({name, "_err"}, err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [IPW-1:0] m320;
      int p0;
      rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; imageResolution = 2'b00;
      DIN = '0; din_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk_mask("rst_dout", DOUT, '0);
      chk_bit("rst_mv", mask_valid, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_err", err, 1'b0);
      rst_n = 1'b1;

      // S1: 640 fill, start coinciding with din_valid drops that chunk
      exp_q.push_back(build(32, 20'h00000));
      do_start(2'b01, 1'b1);
      for (int k = 0; k < 32; k++) drive_chunk(OPW'(k));
      chk_bit("s1_mv_early", mask_valid, 1'b0);
      idle(1);
      chk_bit("s1_mv_latency", mask_valid, 1'b1);
      chk_bit("s1_busy_done", busy, 1'b0);
      chk_w("s1_low_chunk", 32'(DOUT[19:0]), 32'h0);
      chk_w("s1_top_chunk", 32'(DOUT[639:620]), 32'h1F);
      chk_bit("s1_upper_zero", |DOUT[1079:640], 1'b0);
      chk_bit("s1_err", err, 1'b0);
      drain("s1_drain");

      // S2: 1080 fill of all ones with gaps
      p0 = pulses;
      exp_q.push_back('1);
      do_start(2'b10, 1'b0);
      for (int k = 0; k < 54; k++) begin
         drive_chunk(20'hFFFFF);
         idle(k % 4);
      end
      idle(3);
      drain("s2_drain");
      chk_w("s2_pulses", 32'(pulses - p0), 32'd1);

      // S3: 320 fill, then aborted 640 fill, then full 640 fill
      m320 = build(16, 20'h30000);
      exp_q.push_back(m320);
      do_start(2'b00, 1'b0);
      for (int k = 0; k < 16; k++) begin
         drive_chunk(20'h30000 + OPW'(k));
         if (k == 0) imageResolution = 2'b10;
      end
      idle(1);
      do_start(2'b01, 1'b0);
      for (int k = 0; k < 5; k++) drive_chunk(20'hBBB00 + OPW'(k));
      chk_bit("s3_busy_aborted", busy, 1'b1);
      chk_mask("s3_hold_aborted", DOUT, m320);
      exp_q.push_back(build(32, 20'hA0000));
      do_start(2'b01, 1'b0);
      for (int k = 0; k < 32; k++) begin
         drive_chunk(20'hA0000 + OPW'(k));
         if (k == 10) begin
            chk_bit("s3_busy_refill", busy, 1'b1);
            chk_mask("s3_hold_refill", DOUT, m320);
         end
      end
      idle(1);
      drain("s3_drain");
      chk_bit("s3_err", err, 1'b0);

      // S5: clock enable toggled, junk offered while disabled
      exp_q.push_back(build(32, 20'h00000));
      @(negedge clk);
      clk_en = 1'b1; start = 1'b1; imageResolution = 2'b01; din_valid = 1'b0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         clk_en = 1'b1; start = 1'b0; din_valid = 1'b1; DIN = OPW'(k);
         @(negedge clk);
         clk_en = 1'b0; din_valid = 1'b1; DIN = 20'hEEEEE;
      end
      chk_bit("s5_mv_first", mask_valid, 1'b1);
      @(negedge clk);
      chk_bit("s5_mv_held", mask_valid, 1'b1);
      clk_en = 1'b1; din_valid = 1'b0;
      @(negedge clk);
      chk_bit("s5_mv_cleared", mask_valid, 1'b0);
      drain("s5_drain");

      // S6: asynchronous reset mid-fill, then a clean fill
      do_start(2'b01, 1'b0);
      for (int k = 0; k < 11; k++) drive_chunk(20'h77700 + OPW'(k));
      do_reset("s6_rst");
      exp_q.push_back(build(32, 20'h55000));
      do_start(2'b01, 1'b0);
      for (int k = 0; k < 32; k++) drive_chunk(20'h55000 + OPW'(k));
      idle(1);
      drain("s6_drain");
      chk_bit("s6_err", err, 1'b0);

      // S4: error conditions
      do_start(2'b11, 1'b0);
      idle(1);
      chk_bit("s4_err_illegal", err, 1'b1);
      chk_bit("s4_busy_illegal", busy, 1'b0);
      do_reset("s4_rst");
      drive_chunk(20'h12345);
      idle(2);
      chk_bit("s4_err_idle_din", err, 1'b1);
      chk_bit("s4_busy_idle_din", busy, 1'b0);
      chk_mask("s4_dout_zero", DOUT, '0);

      idle(2);
      drain("final_drain");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
